// File: rtl/and_chk_pkg.sv
// Shared types and helpers for the and_custom result checker.
package and_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int MAX_DUT_LATENCY = 7;
  localparam int FILL_W          = 3;
  localparam int SAT_W           = 32;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val);
    logic [SAT_W-1:0] res;
    if (val >= max_val) begin
      res = max_val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/exp_delay_line.sv
// Delays the expected A&B bit by DEPTH cycles; DEPTH==0 is a plain wire.
module exp_delay_line #(
  parameter int DEPTH = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  localparam int STORE = (DEPTH == 0) ? 1 : DEPTH;
  localparam int TAP   = (DEPTH == 0) ? 0 : DEPTH - 1;

  logic [STORE-1:0] r_taps;

  // Shift register, bit 0 is the newest sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_taps <= {STORE{1'b0}};
    end else begin
      r_taps[0] <= i_d;
      for (int i = 1; i < STORE; i++) begin
        r_taps[i] <= r_taps[i-1];
      end
    end
  end

  assign o_q = (DEPTH == 0) ? i_d : r_taps[TAP];

endmodule

// File: rtl/and_result_checker.sv
// Compares and_custom output S against a latency-aligned A&B, counts
// compares and mismatches, and reports a pass/done verdict per run.
module and_result_checker
  import and_chk_pkg::*;
#(
  parameter int CHECK_CYCLES = 16,
  parameter int DUT_LATENCY  = 0,
  parameter int ERR_W        = 8,
  localparam int CNT_W       = $clog2(CHECK_CYCLES + 1)
) (
  input  logic             test_clock,
  input  logic             reset_l,
  input  logic             start,
  input  logic             A,
  input  logic             B,
  input  logic             S,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] cyc_count,
  output logic [CNT_W-1:0] first_err_cycle
);

  localparam int LAT_EFF = (DUT_LATENCY > MAX_DUT_LATENCY) ? MAX_DUT_LATENCY : DUT_LATENCY;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LAT_EFF - 1);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(CHECK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONES  = {CNT_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_ONES  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_ZERO  = {ERR_W{1'b0}};
  localparam state_e RUN_ENTRY = (LAT_EFF == 0) ? ST_CHECK : ST_FILL;

  state_e            r_state;
  state_e            w_state_next;
  logic [FILL_W-1:0] r_fill_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_mismatch;
  logic [ERR_W-1:0]  r_err_count;
  logic [CNT_W-1:0]  r_cyc_count;
  logic [CNT_W-1:0]  r_first_err;

  logic              w_exp;
  logic              w_miss;
  logic              w_start_run;
  logic              w_last_cmp;
  logic [ERR_W-1:0]  w_err_inc;
  logic [ERR_W-1:0]  w_err_after;

  exp_delay_line #(
    .DEPTH (LAT_EFF)
  ) u_exp_delay (
    .i_clk   (test_clock),
    .i_rst_n (reset_l),
    .i_d     (A & B),
    .o_q     (w_exp)
  );

  // Case inequality so an unknown S is reported as a failure.
  assign w_miss      = (S !== w_exp);
  assign w_start_run = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_cmp  = (r_state == ST_CHECK) && (r_cyc_count == LAST_IDX);
  assign w_err_inc   = ERR_W'(sat_inc(SAT_W'(r_err_count), SAT_W'(ERR_ONES)));
  assign w_err_after = w_miss ? w_err_inc : r_err_count;

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = RUN_ENTRY;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (r_fill_cnt == FILL_LAST) begin
          w_state_next = ST_CHECK;
        end else begin
          w_state_next = ST_FILL;
        end
      end
      ST_CHECK: begin
        if (r_cyc_count == LAST_IDX) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_CHECK;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_next = RUN_ENTRY;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge test_clock or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Run counters and verdict registers.
  always_ff @(posedge test_clock or negedge reset_l) begin
    if (!reset_l) begin
      r_fill_cnt  <= {FILL_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_mismatch  <= 1'b0;
      r_err_count <= ERR_ZERO;
      r_cyc_count <= {CNT_W{1'b0}};
      r_first_err <= CNT_ONES;
    end else begin
      r_busy     <= (w_state_next == ST_FILL) || (w_state_next == ST_CHECK);
      r_mismatch <= (r_state == ST_CHECK) && w_miss;
      if (w_start_run) begin
        r_fill_cnt  <= {FILL_W{1'b0}};
        r_done      <= 1'b0;
        r_pass      <= 1'b0;
        r_err_count <= ERR_ZERO;
        r_cyc_count <= {CNT_W{1'b0}};
        r_first_err <= CNT_ONES;
      end else if (r_state == ST_FILL) begin
        r_fill_cnt <= r_fill_cnt + FILL_W'(1'b1);
      end else if (r_state == ST_CHECK) begin
        r_cyc_count <= r_cyc_count + CNT_W'(1'b1);
        r_err_count <= w_err_after;
        if (w_miss && (r_err_count == ERR_ZERO)) begin
          r_first_err <= r_cyc_count;
        end else begin
          r_first_err <= r_first_err;
        end
        if (w_last_cmp) begin
          r_done <= 1'b1;
          r_pass <= (w_err_after == ERR_ZERO);
        end else begin
          r_done <= r_done;
          r_pass <= r_pass;
        end
      end else begin
        r_fill_cnt <= r_fill_cnt;
      end
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign mismatch        = r_mismatch;
  assign err_count       = r_err_count;
  assign cyc_count       = r_cyc_count;
  assign first_err_cycle = r_first_err;

endmodule
